// File: rtl/bus_slot_arbiter_if.sv
// Signal bundle between the slot arbiter, its requester channels, the CPU and the shared RAM bus.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface bus_slot_arbiter_if #(
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_CH-1:0]            ch_valid_i;
   logic [NUM_CH-1:0]            ch_rw_n_i;
   logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data_i;
   logic [NUM_CH-1:0]            ch_ready_o;
   logic [DATA_WIDTH-1:0]        ch_rd_data_o;
   logic [NUM_CH-1:0]            gnt_o;
   logic                         cpu_valid_i;
   logic                         clk_cpu_o;
   logic                         cpu_en_o;
   logic                         bus_en_o;
   logic [ADDR_WIDTH-1:0]        bus_addr_o;
   logic                         bus_rw_n_o;
   logic [DATA_WIDTH-1:0]        bus_wr_data_o;
   logic [DATA_WIDTH-1:0]        bus_rd_data_i;
   logic                         ram_oe_no;
   logic                         ram_we_no;

   modport slave (
      input  ch_valid_i, ch_rw_n_i, ch_addr_i, ch_wr_data_i, cpu_valid_i, bus_rd_data_i,
      output ch_ready_o, ch_rd_data_o, gnt_o, clk_cpu_o, cpu_en_o, bus_en_o,
             bus_addr_o, bus_rw_n_o, bus_wr_data_o, ram_oe_no, ram_we_no
   );

   modport master (
      output ch_valid_i, ch_rw_n_i, ch_addr_i, ch_wr_data_i, cpu_valid_i, bus_rd_data_i,
      input  ch_ready_o, ch_rd_data_o, gnt_o, clk_cpu_o, cpu_en_o, bus_en_o,
             bus_addr_o, bus_rw_n_o, bus_wr_data_o, ram_oe_no, ram_we_no
   );
endinterface

// File: rtl/bus_slot_arbiter.sv
// Time-sliced arbiter for the shared system bus: channel slots granted by fixed priority or
// round robin, one trailing CPU slot per CPU cycle, registered bus strobes and a ready pulse.
module bus_slot_arbiter #(
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8,
   parameter int CYCLE_LEN  = 16,
   parameter int SLOT_LEN   = 4,
   parameter int MODE       = 1
) (
   input logic              clk_16_i,
   input logic              reset_nai,
   bus_slot_arbiter_if.slave io
);
   localparam int PHASE_W = $clog2(CYCLE_LEN);
   localparam int SUB_W   = $clog2(SLOT_LEN);
   localparam int SLOT_W  = PHASE_W - SUB_W;
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [SLOT_W-1:0] CPU_SLOT   = SLOT_W'(CYCLE_LEN / SLOT_LEN - 1);
   localparam logic [SUB_W-1:0]  LAST_SUB   = SUB_W'(SLOT_LEN - 1);
   localparam logic [SUB_W-1:0]  PENULT_SUB = SUB_W'(SLOT_LEN - 2);

   typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_WRITE} slot_state_t;

   slot_state_t           state;
   logic [PHASE_W-1:0]    phase;
   logic [SUB_W-1:0]      sub;
   logic [SLOT_W-1:0]     slot;
   logic                  cpu_slot;
   logic [CH_W-1:0]       rr_ptr;
   logic [CH_W-1:0]       owner;
   logic [CH_W-1:0]       winner;
   logic                  found;
   logic [NUM_CH-1:0]     gnt;
   logic [NUM_CH-1:0]     ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  bus_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  rw_n;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  oe_n;
   logic                  we_n;
   logic [ADDR_WIDTH-1:0] ch_addr    [NUM_CH];
   logic [DATA_WIDTH-1:0] ch_wr_data [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign ch_addr[g]    = io.ch_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign ch_wr_data[g] = io.ch_wr_data_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign sub      = phase[SUB_W-1:0];
   assign slot     = phase[PHASE_W-1:SUB_W];
   assign cpu_slot = (slot == CPU_SLOT);

   // Round robin searches upward starting just past the last winner, wrapping at NUM_CH.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!found) begin
            if (MODE == 0) begin
               if (io.ch_valid_i[CH_W'(k - 1)]) begin
                  found  = 1'b1;
                  winner = CH_W'(k - 1);
               end
            end else if (io.ch_valid_i[CH_W'((int'(rr_ptr) + k) % NUM_CH)]) begin
               found  = 1'b1;
               winner = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            end
         end
      end
   end

   always_ff @(posedge clk_16_i or negedge reset_nai) begin
      if (!reset_nai) begin
         phase   <= '0;
         state   <= SLOT_IDLE;
         rr_ptr  <= CH_W'(NUM_CH - 1);
         owner   <= '0;
         gnt     <= '0;
         ready   <= '0;
         rd_data <= '0;
         bus_en  <= 1'b0;
         addr    <= '0;
         rw_n    <= 1'b1;
         wr_data <= '0;
         oe_n    <= 1'b1;
         we_n    <= 1'b1;
      end else begin
         phase <= phase + 1'b1;
         ready <= '0;
         if (!cpu_slot && sub == '0) begin
            if (found) begin
               state   <= io.ch_rw_n_i[winner] ? SLOT_READ : SLOT_WRITE;
               owner   <= winner;
               gnt     <= NUM_CH'(1) << winner;
               bus_en  <= 1'b1;
               addr    <= ch_addr[winner];
               rw_n    <= io.ch_rw_n_i[winner];
               wr_data <= ch_wr_data[winner];
               oe_n    <= ~io.ch_rw_n_i[winner];
               we_n    <= io.ch_rw_n_i[winner];
               if (MODE != 0) begin
                  rr_ptr <= winner;
               end
            end
         end else if (state != SLOT_IDLE) begin
            // WE rises one tick early so address and data are still held across its rising edge.
            if (sub == PENULT_SUB) begin
               we_n         <= 1'b1;
               ready[owner] <= 1'b1;
               if (state == SLOT_READ) begin
                  rd_data <= io.bus_rd_data_i;
               end
            end
            if (sub == LAST_SUB) begin
               state   <= SLOT_IDLE;
               gnt     <= '0;
               bus_en  <= 1'b0;
               addr    <= '0;
               rw_n    <= 1'b1;
               wr_data <= '0;
               oe_n    <= 1'b1;
               we_n    <= 1'b1;
            end
         end
      end
   end

   assign io.gnt_o         = gnt;
   assign io.ch_ready_o    = ready;
   assign io.ch_rd_data_o  = rd_data;
   assign io.bus_en_o      = bus_en;
   assign io.bus_addr_o    = addr;
   assign io.bus_rw_n_o    = rw_n;
   assign io.bus_wr_data_o = wr_data;
   assign io.ram_oe_no     = oe_n;
   assign io.ram_we_no     = we_n;
   assign io.clk_cpu_o     = phase[PHASE_W-1];
   assign io.cpu_en_o      = cpu_slot & io.cpu_valid_i;
endmodule
